// File: rtl/mul_seq_32bit.sv
// ---------------------------------------------------------------------------
// mul_seq_32bit
//
// Sequential 32 x 32 -> 64 bit shift-and-add multiplier. One operand pair is
// accepted on a valid/ready handshake. The block then spends 32 BUSY cycles
// doing one add-and-shift step per cycle, and holds the product in DONE until
// downstream takes it.
//
// Optional feature (macro MUL_SIGNED_EN):
//   When defined, a signed_i port is added. An operation accepted with
//   signed_i=1 multiplies the operand magnitudes. It then passes through one
//   extra NEG cycle, which negates the 64-bit result when the operand signs
//   differ. When undefined, every operation is unsigned and the NEG state and
//   sign logic do not exist.
//
// Ports:
//   clk_i      in   1   clock, all state changes on the rising edge
//   rst_i      in   1   synchronous active-high reset
//   valid_i    in   1   operand request valid
//   ready_o    out  1   block can accept operands (IDLE only)
//   a_i        in  32   multiplicand, sampled on accept
//   b_i        in  32   multiplier, sampled on accept
//   signed_i   in   1   two's-complement mode (MUL_SIGNED_EN only)
//   product_o  out 64   result, meaningful while valid_o=1
//   valid_o    out  1   result available
//   ready_i    in   1   downstream accepts the result
//
// Latency: counting the accept edge as edge 1, valid_o first reads high after
// edge 33 for an unsigned operation. A signed_i=1 operation adds one cycle
// and reads high after edge 34.
// ---------------------------------------------------------------------------
module mul_seq_32bit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
`ifdef MUL_SIGNED_EN
    input  logic        signed_i,
`endif
    output logic [63:0] product_o,
    output logic        valid_o,
    input  logic        ready_i
);

    // NEG only exists when signed support is built in. DONE keeps the same
    // encoding in both builds.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
`ifdef MUL_SIGNED_EN
        NEG  = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic [4:0]  stepCount_q;
    logic [63:0] working_q;
    logic [63:0] working_d;
    logic [31:0] multiplicand_q;
    logic        ready_q;
    logic        valid_q;

    logic [31:0] addend;
    logic [31:0] partialSum;
    logic        partialCarry;

    logic [31:0] aOperand;
    logic [31:0] bOperand;

`ifdef MUL_SIGNED_EN
    logic        negate_q;
    logic        signedOp_q;
    logic [63:0] negated;

    // In signed mode each negative operand is replaced by its magnitude, so
    // the BUSY datapath only ever multiplies unsigned values. 0x80000000
    // negates to itself, and read as unsigned that is its true magnitude.
    always_comb begin
        aOperand = a_i;
        bOperand = b_i;
        if (signed_i) begin
            if (a_i[31]) begin
                aOperand = ~a_i + 32'd1;
            end
            if (b_i[31]) begin
                bOperand = ~b_i + 32'd1;
            end
        end
    end

    // Two's-complement negate of the finished magnitude product, used by NEG.
    always_comb begin
        negated = ~working_q + 64'd1;
    end
`else
    // Unsigned-only build: operands go into the datapath untouched.
    always_comb begin
        aOperand = a_i;
        bOperand = b_i;
    end
`endif

    // The multiplier bit currently in the LSB of the working register decides
    // whether this step adds the multiplicand or adds nothing.
    always_comb begin
        addend = working_q[0] ? multiplicand_q : 32'h0;
    end

    // One shared ripple adder forms the upper-half partial sum every cycle.
    RippleAdder32 uAdder (
        .a_i     (working_q[63:32]),
        .b_i     (addend),
        .carry_i (1'b0),
        .sum_o   (partialSum),
        .carry_o (partialCarry)
    );

    // Next working value for one BUSY step. {carry, sum, low half} is shifted
    // right by one. The carry becomes the new MSB, and the used multiplier
    // bit drops off the bottom.
    always_comb begin
        working_d = {partialCarry, partialSum, working_q[31:1]};
    end

    // Control FSM with registered handshake outputs.
    // ready_q and valid_q are updated on the same edge as the state change,
    // so they always match the state being entered. Reset takes priority
    // over any handshake. DONE holds working_q untouched, which keeps
    // product_o stable until the result is taken.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            stepCount_q    <= 5'd0;
            working_q      <= 64'h0;
            multiplicand_q <= 32'h0;
            ready_q        <= 1'b1;
            valid_q        <= 1'b0;
`ifdef MUL_SIGNED_EN
            negate_q       <= 1'b0;
            signedOp_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i && ready_q) begin
                        state_q        <= BUSY;
                        stepCount_q    <= 5'd0;
                        working_q      <= {32'h0, bOperand};
                        multiplicand_q <= aOperand;
                        ready_q        <= 1'b0;
                        valid_q        <= 1'b0;
`ifdef MUL_SIGNED_EN
                        negate_q       <= signed_i & (a_i[31] ^ b_i[31]);
                        signedOp_q     <= signed_i;
`endif
                    end
                end

                BUSY: begin
                    working_q   <= working_d;
                    stepCount_q <= stepCount_q + 5'd1;
                    if (stepCount_q == 5'd31) begin
`ifdef MUL_SIGNED_EN
                        if (signedOp_q) begin
                            state_q <= NEG;
                        end else begin
                            state_q <= DONE;
                            valid_q <= 1'b1;
                        end
`else
                        state_q <= DONE;
                        valid_q <= 1'b1;
`endif
                    end
                end

`ifdef MUL_SIGNED_EN
                NEG: begin
                    if (negate_q) begin
                        working_q <= negated;
                    end
                    state_q <= DONE;
                    valid_q <= 1'b1;
                end
`endif

                DONE: begin
                    if (valid_q && ready_i) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    // Reset clears working_q, so product_o reads zero straight out of reset.
    always_comb begin
        ready_o   = ready_q;
        valid_o   = valid_q;
        product_o = working_q;
    end

endmodule

// ---------------------------------------------------------------------------
// RippleAdder32
//
// Plain 32-bit ripple-carry adder built from per-bit full-adder equations.
//
// Ports:
//   a_i      in  32  first addend
//   b_i      in  32  second addend
//   carry_i  in   1  carry into bit 0
//   sum_o    out 32  sum
//   carry_o  out  1  carry out of bit 31
// ---------------------------------------------------------------------------
module RippleAdder32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        carry_i,
    output logic [31:0] sum_o,
    output logic        carry_o
);

    logic [32:0] carryChain;

    assign carryChain[0] = carry_i;

    // Each stage is a textbook full adder. The carry ripples from bit 0
    // upward, and the final carry becomes carry_o.
    genvar bitIdx;
    generate
        for (bitIdx = 0; bitIdx < 32; bitIdx = bitIdx + 1) begin : gBit
            assign sum_o[bitIdx]        = a_i[bitIdx] ^ b_i[bitIdx] ^ carryChain[bitIdx];
            assign carryChain[bitIdx+1] = (a_i[bitIdx] & b_i[bitIdx])
                                        | (carryChain[bitIdx] & (a_i[bitIdx] ^ b_i[bitIdx]));
        end
    endgenerate

    assign carry_o = carryChain[32];

endmodule
